serial_addsub: RTL



---
 rtl/serial_addsub.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor.
// Two operands are latched and fed LSB first through a one-bit full-adder
// cell with a registered carry. The sum bits are collected and the result is
// returned with carry, signed-overflow and zero flags over a valid/ready
// handshake.
module serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;

    // One-bit full-adder cell on the current LSB pair.
    logic             bit_s;
    logic             bit_c;
    logic             last_bit;
    logic [WIDTH-1:0] result_next;

    assign {bit_c, bit_s} = {1'b0, a_sh_reg[0]} + {1'b0, b_sh_reg[0]} + {1'b0, carry_reg};
    assign last_bit       = (count_reg == CW'(WIDTH - 1));
    assign result_next    = {bit_s, result_reg[WIDTH-1:1]};

    // Handshake outputs decode from the state only.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand load, serial add step, and result/flag capture on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                        a_sh_reg   <= a;
                        b_sh_reg   <= sub ? ~b : b;
                        carry_reg  <= sub;
                        result_reg <= '0;
                        count_reg  <= '0;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    carry_reg  <= bit_c;
                    if (last_bit) begin
                        // carry_reg is the carry into the MSB during this step,
                        // so overflow is formed directly from the live value.
                        sum      <= result_next;
                        cout     <= bit_c;
                        overflow <= carry_reg ^ bit_c;
                        zero     <= (result_next == '0);
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
